// File: rtl/alu_divider_if.sv
// rtl/alu_divider_if.sv - Request/result bundle between the datapath controller and alu_divider
interface alu_divider_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Start;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             DivByZero;
  logic             ZeroFlag;

  modport master (
    output A, B, Start,
    input  Busy, Done, Quotient, Remainder, DivByZero, ZeroFlag
  );

  modport slave (
    input  A, B, Start,
    output Busy, Done, Quotient, Remainder, DivByZero, ZeroFlag
  );
endinterface

// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - Multi-cycle unsigned restoring divider, one quotient bit per clock
module alu_divider #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_divider_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             busy;
  logic             done;

  logic [WIDTH:0]   r_shift;
  logic             fits;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] dq_step;

  // When the divisor fits, the true difference is below 2^WIDTH, so the
  // WIDTH-bit modular subtraction is exact.
  always_comb begin
    r_shift = {r, dividend[WIDTH-1]};
    fits    = (r_shift >= {1'b0, divisor});
    r_step  = fits ? (r_shift[WIDTH-1:0] - divisor) : r_shift[WIDTH-1:0];
    dq_step = {dividend[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) begin
          state_next = (bus.B == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (count == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The dividend register doubles as the quotient: each shift frees its LSB,
  // which takes the new quotient bit, so after WIDTH steps it holds floor(A/B).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      dividend    <= '0;
      divisor     <= '0;
      r           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            if (bus.B == '0) begin
              quotient    <= '1;
              remainder   <= bus.A;
              div_by_zero <= 1'b1;
            end else begin
              dividend <= bus.A;
              divisor  <= bus.B;
              r        <= '0;
              count    <= '0;
            end
          end
        end
        CALC: begin
          dividend <= dq_step;
          r        <= r_step;
          count    <= count + CW'(1);
          if (count == LAST) begin
            quotient    <= dq_step;
            remainder   <= r_step;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.Quotient  = quotient;
  assign bus.Remainder = remainder;
  assign bus.DivByZero = div_by_zero;
  assign bus.ZeroFlag  = (quotient == '0);

endmodule

// File: doc/alu_divider.md
# alu_divider

Multi-cycle unsigned integer divider that complements the 8-bit combinational ALU, whose operation set includes multiply but no divide. It accepts a dividend/divisor pair on a start strobe and runs a restoring shift-subtract algorithm, one quotient bit per clock. It returns quotient, remainder and flags with a one-cycle done pulse. It sits beside the ALU in the datapath and is driven by the same controller that selects ALU operations.

## Interface
- WIDTH, 8: operand, quotient and remainder width in bits; must be 2 or greater.
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  WIDTH  dividend; sampled only on an accepted Start.
- B  input  WIDTH  divisor; sampled only on an accepted Start.
- Start  input  1  request strobe; accepted only when Busy=0.
- Busy  output  1  high from the edge after an accepted Start through the Done cycle.
- Done  output  1  one-cycle pulse; Quotient, Remainder and DivByZero are valid from this cycle on.
- Quotient  output  WIDTH  floor(A/B); all ones if B=0.
- Remainder  output  WIDTH  A mod B; equals A if B=0.
- DivByZero  output  1  set when the last accepted operation had B=0.
- ZeroFlag  output  1  combinational: Quotient==0.

## Operation
- FSM states:
  - IDLE: Busy=0, Done=0.
  - CALC: Busy=1, Done=0.
  - DONE: Busy=1, Done=1.
- Transitions:
  - IDLE with Start=1 and B≠0 goes to CALC. A and B are latched, the partial remainder r (WIDTH+1 bits) is cleared, and the iteration counter is cleared.
  - IDLE with Start=1 and B=0 goes directly to DONE. The edge loads Quotient={WIDTH{1}}, Remainder=A and DivByZero=1.
  - CALC performs one iteration per edge. After WIDTH iterations it goes to DONE. That edge loads Quotient, Remainder and DivByZero=0.
  - DONE always goes to IDLE on the next edge.
- Iteration: r ← {r[WIDTH-1:0], dividend MSB}, then the dividend shifts left by one.
  - If r ≥ divisor: r ← r − divisor and shift 1 into the quotient LSB.
  - Otherwise: shift 0 into the quotient LSB.
  - r never exceeds WIDTH+1 bits. The final r fits in WIDTH bits.
- Output registers change only on the edge that enters DONE. They hold their values across IDLE and the next CALC until the next completion.
- Start is ignored in CALC and DONE; it is not queued. A and B may change freely after the accepting edge.
- Unsigned arithmetic only. Invariant: Quotient*B + Remainder == A, with Remainder < B, whenever B≠0.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE, counter=0, internal shift registers=0;
  - Busy=0, Done=0, Quotient=0, Remainder=0, DivByZero=0;
  - ZeroFlag=1.
- Reset released: the first edge with rst_n=1 may accept a Start.
- Normal latency: Start is accepted at edge T0. Busy=1 after T0. Iterations occur at T1..T_WIDTH (T8 by default). Done=1 and the results are valid after T_WIDTH. After T_WIDTH+1, Busy=0 and Done=0.
- Divide by zero: Start is accepted at T0. Done=1 and Busy=1 after T0. Both are 0 after T1.
- Back-to-back throughput: the earliest next accept is at the edge ending the DONE cycle +1. A new request is therefore accepted every WIDTH+2 edges, or every 2 edges for divide by zero.
- Reset mid-CALC or mid-DONE aborts the operation immediately. No Done pulse is produced and the outputs go to their reset values.
- Start held high continuously: a new operation is accepted at every return to IDLE.

## Test plan
- A=100, B=7, single Start at T0 -> Busy high after T0; Done exactly after T8 for one cycle; Quotient=14, Remainder=2, DivByZero=0, ZeroFlag=0.
- A=255, B=1, then A=255, B=255, then A=0, B=13 -> Q/R = 255/0, then 1/0, then 0/0; ZeroFlag=1 on the last.
- A=5, B=9 -> Quotient=0, Remainder=5, ZeroFlag=1. Then A=42, B=0 -> Done after T1, Quotient=8'hFF, Remainder=42, DivByZero=1, ZeroFlag=0.
- A=200, B=3 accepted; Start pulsed with A=9, B=9 at T3 and in the DONE cycle -> both ignored; result 66/2. Start one cycle after DONE -> accepted, result 1/0.
- Reset pulled low asynchronously mid-CALC (between T4 and T5) -> all outputs return to reset values without waiting for an edge; no Done pulse. After release, A=17, B=4 -> 4/1 with normal latency.
- Random unsigned A and B including B=0, ≥10k operations with random Start gaps, checked against a reference model -> Quotient*B + Remainder == A and Remainder < B; Done pulses exactly once per accepted Start.
